// File: rtl/scope_capture.sv
`default_nettype none
// ============================================================================
// Module   : scope_capture
// Purpose  : Triggered 8-bit oscilloscope capture buffer fed at the audio sample rate.
// Revision : 1.0 - initial release
// ============================================================================
module scope_capture #(
    parameter int ADDR_W = 9
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              sampleclk,
    input  logic [23:0]       sndCapL,
    input  logic [23:0]       sndCapR,
    input  logic              chan_sel,
    input  logic [3:0]        decim,
    input  logic              trig_en,
    input  logic [7:0]        trig_level,
    input  logic              arm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [1:0]        state,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_sclk_q, r_sclk_qq;
    logic [3:0]         r_dcnt, w_dcnt_nxt;
    logic [ADDR_W-1:0]  r_ptr, w_ptr_nxt;
    logic signed [7:0]  r_prev, w_prev_nxt;
    logic               r_prev_vld, w_prev_vld_nxt;
    logic [7:0]         r_mem [0:(1<<ADDR_W)-1];
    logic [7:0]         r_rd_data;

    logic               w_strobe;
    logic signed [7:0]  w_sample;
    logic signed [7:0]  w_level;
    logic               w_accept;
    logic               w_trig;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic               w_unused;

    assign w_unused = ^{sndCapL[15:0], sndCapR[15:0]};

    // Rising edge of sampleclk seen one cycle late gives a single-cycle strobe.
    assign w_strobe = r_sclk_q & ~r_sclk_qq;
    assign w_sample = chan_sel ? sndCapR[23:16] : sndCapL[23:16];
    assign w_level  = trig_level;
    assign w_accept = w_strobe & ~arm & (r_dcnt == decim) &
                      ((r_state == S_WAIT) | (r_state == S_CAPT));
    assign w_trig   = ~trig_en | (r_prev_vld & (r_prev < w_level) & (w_sample >= w_level));

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sclk_q   <= 1'b0;
            r_sclk_qq  <= 1'b0;
            r_dcnt     <= 4'd0;
            r_ptr      <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sclk_q   <= sampleclk;
            r_sclk_qq  <= r_sclk_q;
            r_dcnt     <= w_dcnt_nxt;
            r_ptr      <= w_ptr_nxt;
            r_prev     <= w_prev_nxt;
            r_prev_vld <= w_prev_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_dcnt_nxt     = r_dcnt;
        w_ptr_nxt      = r_ptr;
        w_prev_nxt     = r_prev;
        w_prev_vld_nxt = r_prev_vld;
        w_we           = 1'b0;
        w_waddr        = r_ptr;
        if (arm) begin
            // A re-arm always wins, even over a sample accepted in the same cycle.
            w_state_nxt    = S_WAIT;
            w_dcnt_nxt     = 4'd0;
            w_ptr_nxt      = '0;
            w_prev_vld_nxt = 1'b0;
        end else begin
            case (r_state)
                S_WAIT, S_CAPT: begin
                    if (w_strobe) begin
                        w_dcnt_nxt = (r_dcnt == decim) ? 4'd0 : r_dcnt + 4'd1;
                    end
                    if (w_accept) begin
                        if (r_state == S_WAIT) begin
                            if (w_trig) begin
                                w_we        = 1'b1;
                                w_waddr     = '0;
                                w_ptr_nxt   = ADDR_W'(1);
                                w_state_nxt = S_CAPT;
                            end else begin
                                w_prev_nxt     = w_sample;
                                w_prev_vld_nxt = 1'b1;
                            end
                        end else begin
                            w_we      = 1'b1;
                            w_waddr   = r_ptr;
                            w_ptr_nxt = r_ptr + ADDR_W'(1);
                            if (r_ptr == c_last_addr) begin
                                w_state_nxt = S_DONE;
                            end
                        end
                    end
                end
                default: begin
                    w_dcnt_nxt = 4'd0;
                end
            endcase
        end
    end

    // Buffer contents survive reset; the reset gate blocks a write on the reset edge.
    always_ff @(posedge sysclk) begin
        if (w_we && !reset) begin
            r_mem[w_waddr] <= w_sample;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_rd_data <= 8'd0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;
    assign state   = r_state;
    assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/scope_capture.md
SCOPE_CAPTURE -- requirements
Module: scope_capture

Interface
REQ-001 Parameter: ADDR_W, 9, buffer address width; buffer depth = 2^ADDR_W samples.
REQ-002 sysclk  in  1  system clock; all logic is synchronous to its rising edge.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 sampleclk  in  1  sample-rate clock from the I2S block, synchronous to sysclk.
REQ-005 sndCapL  in  24  captured left sample, signed two's complement, stable around sampleclk rise.
REQ-006 sndCapR  in  24  captured right sample, signed two's complement.
REQ-007 chan_sel  in  1  source channel: 0 = sndCapL, 1 = sndCapR.
REQ-008 decim  in  4  decimation: store one of every decim+1 samples.
REQ-009 trig_en  in  1  1 = wait for trigger, 0 = free-run.
REQ-010 trig_level  in  8  signed trigger threshold.
REQ-011 arm  in  1  single-cycle pulse that starts or restarts an acquisition.
REQ-012 rd_addr  in  ADDR_W  display read address.
REQ-013 rd_data  out  8  signed buffer word at rd_addr.
REQ-014 state  out  2  FSM state: 0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 DONE.
REQ-015 done  out  1  high while state = DONE.

Function
REQ-016 Strobe: one-cycle pulse in the cycle after sampleclk is first sampled 1 following a sampled 0; sampleclk held high yields exactly one strobe.
REQ-017 Sample value s = selected channel bits [23:16], latched on the strobe cycle; chan_sel is sampled on the strobe cycle.
REQ-018 Decimation counter: increments on each strobe; on a strobe where counter = decim, the sample is accepted and the counter returns to 0; decim = 0 accepts every strobe.
REQ-019 Decimation counter is cleared on arm and held at 0 in IDLE and DONE.
REQ-020 IDLE: no writes; arm -> WAIT_TRIG.
REQ-021 WAIT_TRIG, trig_en = 0: first accepted sample is written to address 0; ptr <= 1; -> CAPTURE.
REQ-022 WAIT_TRIG, trig_en = 1: trigger when prev < trig_level and s >= trig_level (signed compare), with prev = previous accepted sample in this WAIT_TRIG; the first accepted sample never triggers.
REQ-023 Triggering sample is written to address 0; ptr <= 1; -> CAPTURE; non-triggering samples only update prev and are not written.
REQ-024 CAPTURE: each accepted sample is written at ptr, and ptr increments; the write to address 2^ADDR_W-1 moves the FSM to DONE in the same edge; ptr wraps to 0.
REQ-025 DONE: no writes, buffer frozen, done = 1; arm -> WAIT_TRIG.
REQ-026 Arm in WAIT_TRIG or CAPTURE restarts the acquisition: ptr = 0, prev invalid, decimation counter 0, -> WAIT_TRIG; previously written words remain until overwritten.
REQ-027 Arm coincident with an accepted sample: the arm wins; the sample is discarded.
REQ-028 Buffer write occurs at the rising edge ending the accepting strobe cycle.
REQ-029 Read: rd_data = mem[rd_addr] registered, 1-cycle latency, valid in every state.
REQ-030 Read and write to the same address in the same cycle returns the old word.
REQ-031 trig_en and trig_level are sampled on every accepted sample, with no shadowing.

Reset
REQ-032 Reset forces state = IDLE, done = 0, rd_data = 0, ptr = 0, decimation counter = 0, prev invalid, and strobe detector previous value = 0.
REQ-033 Buffer memory contents are not reset.
REQ-034 Reset mid-CAPTURE aborts immediately; no write occurs in the reset cycle.

Verification
REQ-035 Free-run capture:
- Stimulus: ADDR_W = 9, trig_en = 0, decim = 0, sndCapL = 24'hAA5A5A, chan_sel = 0, arm pulse, 512 sampleclk rises.
- Required response: done = 1 after the 512th strobe; every rd_data = 8'hAA with 1-cycle latency.
REQ-036 Trigger crossing:
- Stimulus: trig_en = 1, trig_level = 8'h10; sndCapR[23:16] sequence 8'hF0, 8'h05, 8'h20, 8'h30; chan_sel = 1.
- Required response: address 0 = 8'h20 and address 1 = 8'h30; state = 2 after 8'h20.
REQ-037 No trigger:
- Stimulus: trig_en = 1, trig_level = 8'h10; samples held at 8'h20.
- Required response: state stays 1; no buffer writes.
REQ-038 Decimation:
- Stimulus: decim = 3, trig_en = 0; ramp 0, 1, 2, ... on successive strobes.
- Required response: buffer holds 3, 7, 11, ...
REQ-039 Arm during CAPTURE:
- Stimulus: arm at ptr = 100.
- Required response: state = 1 and ptr = 0; the next capture overwrites from address 0.
- Stimulus: arm coincident with a strobe.
- Required response: that sample is not written.
REQ-040 Reset mid-operation:
- Stimulus: reset asserted for 100 ns in CAPTURE.
- Required response: state = 0, done = 0, rd_data = 0 immediately; no writes until the next arm.
